dbgreader: RTL and testbench

Sequential, parametrised debug read engine between the external debug link and the core's register file, data memory and PC. It accepts a request naming a source space, a start index and a burst length. It sequences reads at one access at a time, absorbing the data memory's configurable read latency, and returns each word with a one-cycle valid pulse. It also owns a free-running cycle counter readable through the special space.

---
 rtl/dbg_pkg.sv | 19 +
 rtl/dbg_cyccnt.sv | 17 +
 rtl/dbgreader.sv | 124 ++++++++++++
 tb/tb_dbgreader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// dbgreader shared definitions.
// Space codes, special indices and FSM states.
package dbg_pkg;

  localparam logic [1:0] DBG_SPACE_REG  = 2'b00;
  localparam logic [1:0] DBG_SPACE_DATA = 2'b01;
  localparam logic [1:0] DBG_SPACE_SPEC = 2'b10;
  localparam logic [1:0] DBG_SPACE_RSVD = 2'b11;

  localparam int DBG_SPEC_PC    = 0;
  localparam int DBG_SPEC_CYCLE = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT
  } dbg_state_t;

endpackage

// File: rtl/dbg_cyccnt.sv
// Free-running cycle counter for the debug special space.
// Wraps naturally at 2^XLEN.
module dbg_cyccnt #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] count
);

  // count every cycle, clear on reset
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count + XLEN'(1);
  end

endmodule

// File: rtl/dbgreader.sv
// Debug read engine: sequences reg/data/special reads.
// One access at a time; data reads wait out MEMLAT.
module dbgreader
  import dbg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SEL_W   = 5,
  parameter int MEMLAT  = 1,
  parameter int BURST_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dbgreq,
  input  logic [SEL_W+1:0]   dbgsel,
  input  logic [BURST_W-1:0] dbglen,
  output logic               dbgbusy,
  output logic               dbgvalid,
  output logic               dbgdone,
  output logic [XLEN-1:0]    dbgout,
  output logic [SEL_W-1:0]   regsel,
  input  logic [XLEN-1:0]    regin,
  output logic [SEL_W-1:0]   datasel,
  output logic               dataen,
  input  logic [XLEN-1:0]    datain,
  input  logic [XLEN-1:0]    pcin
);

  localparam logic [1:0] WINIT = 2'(MEMLAT - 1);

  dbg_state_t         state, nstate;
  logic [1:0]         space;
  logic [SEL_W-1:0]   idx;
  logic [BURST_W-1:0] rem;
  logic [1:0]         wcnt;
  logic [XLEN-1:0]    cyc;
  logic [XLEN-1:0]    rdval;
  logic               capture;
  logic               accept;

  dbg_cyccnt #(
    .XLEN (XLEN)
  ) u_cyccnt (
    .clk   (clk),
    .rst   (rst),
    .count (cyc)
  );

  assign accept = (state == IDLE) && dbgreq;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // next state and word-capture decision
  always_comb begin
    nstate  = state;
    capture = 1'b0;
    unique case (state)
      IDLE: if (dbgreq) nstate = READ;
      READ: begin
        if (space == DBG_SPACE_DATA) nstate = WAIT;
        else capture = 1'b1;
      end
      WAIT: if (wcnt == 2'd0) capture = 1'b1;
      default: nstate = IDLE;
    endcase
    if (capture) nstate = (rem == '0) ? IDLE : READ;
  end

  // strobes, selects and read-data mux
  always_comb begin
    dbgbusy = (state != IDLE);
    dataen  = (state == READ) && (space == DBG_SPACE_DATA);
    regsel  = idx;
    datasel = idx;
    rdval   = '0;
    unique case (space)
      DBG_SPACE_REG:  rdval = regin;
      DBG_SPACE_DATA: rdval = datain;
      DBG_SPACE_SPEC: begin
        if (idx == SEL_W'(DBG_SPEC_PC))
          rdval = pcin;
        else if (idx == SEL_W'(DBG_SPEC_CYCLE))
          rdval = cyc;
      end
      default: rdval = '0;
    endcase
  end

  // burst bookkeeping and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      space    <= DBG_SPACE_REG;
      idx      <= '0;
      rem      <= '0;
      wcnt     <= '0;
      dbgout   <= '0;
      dbgvalid <= 1'b0;
      dbgdone  <= 1'b0;
    end else begin
      dbgvalid <= capture;
      dbgdone  <= capture && (rem == '0);
      if (accept) begin
        space <= dbgsel[SEL_W+1:SEL_W];
        idx   <= dbgsel[SEL_W-1:0];
        rem   <= dbglen;
      end
      if (dataen)
        wcnt <= WINIT;
      else if (state == WAIT && wcnt != 2'd0)
        wcnt <= wcnt - 2'd1;
      if (capture) begin
        dbgout <= rdval;
        if (rem != '0) begin
          rem <= rem - BURST_W'(1);
          idx <= idx + SEL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dbgreader.sv
// Scoreboard bench for dbgreader (MEMLAT = 2).
// Model predicts words, timing and data strobes.
module tb_dbgreader;

  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbgreq;
  logic [6:0]  dbgsel;
  logic [4:0]  dbglen;
  logic        dbgbusy, dbgvalid, dbgdone, dataen;
  logic [31:0] dbgout, regin, datain, pcin;
  logic [4:0]  regsel, datasel;

  logic [31:0] regfile [32];
  logic [31:0] mem [32];
  logic [31:0] pipe [ML];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    bit          done;
  } exp_t;
  typedef struct {
    int unsigned cyc;
    logic [4:0]  sel;
  } acc_t;

  exp_t wq[$];
  acc_t aq[$];

  int unsigned en = 0;
  int unsigned free_edge = 0;
  logic [31:0] tbcyc = 0;
  bit          mon_on = 0;

  always #5 clk = ~clk;

  dbgreader #(
    .XLEN(32), .SEL_W(5), .MEMLAT(ML), .BURST_W(5)
  ) dut (
    .clk(clk), .rst(rst), .dbgreq(dbgreq),
    .dbgsel(dbgsel), .dbglen(dbglen),
    .dbgbusy(dbgbusy), .dbgvalid(dbgvalid),
    .dbgdone(dbgdone), .dbgout(dbgout),
    .regsel(regsel), .regin(regin),
    .datasel(datasel), .dataen(dataen),
    .datain(datain), .pcin(pcin)
  );

  assign regin  = regfile[regsel];
  assign datain = pipe[ML-1];

  // memory with ML-cycle read latency; junk when not strobed
  always @(posedge clk) begin
    pipe[0] <= dataen ? mem[datasel] : $urandom;
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference model: acceptance and expected words
  logic [1:0]  m_sp;
  logic [4:0]  m_ix;
  int unsigned m_n, m_per;
  logic [31:0] m_d;
  always @(posedge clk) begin
    en++;
    if (rst) begin
      wq.delete();
      aq.delete();
      free_edge = en + 1;
      tbcyc = 0;
    end else begin
      if (dbgreq && en >= free_edge) begin
        m_sp  = dbgsel[6:5];
        m_n   = int'(dbglen) + 1;
        m_per = (m_sp == 2'b01) ? 1 + ML : 1;
        for (int i = 0; i < int'(m_n); i++) begin
          m_ix = dbgsel[4:0] + 5'(i);
          case (m_sp)
            2'b00: m_d = regfile[m_ix];
            2'b01: m_d = mem[m_ix];
            2'b10: m_d = (m_ix == 0) ? pcin :
                         (m_ix == 1) ? tbcyc + 32'(i + 1) : 32'h0;
            default: m_d = 32'h0;
          endcase
          wq.push_back('{en + (i + 1) * m_per, m_d, i == int'(m_n) - 1});
          if (m_sp == 2'b01)
            aq.push_back('{en + i * m_per, m_ix});
        end
        free_edge = en + m_n * m_per + 1;
      end
      tbcyc++;
    end
  end

  // monitor: compare DUT presentations against the queues
  exp_t e;
  acc_t a;
  always @(negedge clk) begin
    if (mon_on) begin
      if (dbgvalid) begin
        if (wq.size() == 0) begin
          check("spurious_valid", 32'd1, 32'd0);
        end else begin
          e = wq.pop_front();
          check("word_data", dbgout, e.data);
          check("word_done", 32'(dbgdone), 32'(e.done));
          check("word_cycle", en, e.cyc);
        end
      end else if (wq.size() != 0 && wq[0].cyc <= en) begin
        e = wq.pop_front();
        check("missing_valid", 32'd0, 32'd1);
      end
      checks++;
      if (dbgdone && !dbgvalid) begin
        failures++;
        $display("FAIL done_without_valid actual=1 required=0");
      end
      if (dataen) begin
        if (aq.size() == 0) begin
          check("spurious_dataen", 32'd1, 32'd0);
        end else begin
          a = aq.pop_front();
          check("dataen_sel", 32'(datasel), 32'(a.sel));
          check("dataen_cycle", en, a.cyc);
        end
      end else if (aq.size() != 0 && aq[0].cyc <= en) begin
        a = aq.pop_front();
        check("missing_dataen", 32'd0, 32'd1);
      end
    end
  end

  task automatic req(input logic [6:0] sel, input logic [4:0] len);
    @(negedge clk);
    dbgreq = 1'b1;
    dbgsel = sel;
    dbglen = len;
    @(negedge clk);
    dbgreq = 1'b0;
  endtask

  task automatic idle_wait();
    for (int k = 0; k < 300 && (wq.size() != 0 || aq.size() != 0); k++)
      @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"}, 32'(dbgvalid), 32'd0);
    check({tag, "_done"}, 32'(dbgdone), 32'd0);
    check({tag, "_busy"}, 32'(dbgbusy), 32'd0);
    check({tag, "_dataen"}, 32'(dataen), 32'd0);
    check({tag, "_regsel"}, 32'(regsel), 32'd0);
    check({tag, "_datasel"}, 32'(datasel), 32'd0);
    check({tag, "_dbgout"}, dbgout, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    dbgreq = 1'b0;
    dbgsel = '0;
    dbglen = '0;
    pcin   = 32'h0000_0400;
    for (int i = 0; i < 32; i++) begin
      regfile[i] = $urandom;
      mem[i]     = $urandom;
    end
    for (int i = 0; i < ML; i++) pipe[i] = '0;
    regfile[5] = 32'hDEAD_BEEF;
    mem[30] = 32'h11;
    mem[31] = 32'h22;
    mem[0]  = 32'h33;

    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    mon_on = 1;
    rst = 1'b0;

    // reg single word, busy exactly one cycle
    req(7'h05, 5'd0);
    check("single_busy_hi", 32'(dbgbusy), 32'd1);
    @(negedge clk);
    check("single_busy_lo", 32'(dbgbusy), 32'd0);
    idle_wait();

    // data burst wrapping 30,31,0
    req(7'h3E, 5'd2);
    idle_wait();

    // special space
    req(7'h40, 5'd0);
    idle_wait();
    req(7'h41, 5'd0);
    idle_wait();
    req(7'h45, 5'd0);
    idle_wait();
    req(7'h5F, 5'd3);
    idle_wait();

    // reserved, with a request pulsed mid-burst
    req(7'h60, 5'd3);
    dbgreq = 1'b1;
    dbgsel = 7'h05;
    dbglen = 5'd0;
    @(negedge clk);
    dbgreq = 1'b0;
    idle_wait();

    // reset after the third word of an 8-word burst
    req(7'h00, 5'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("midreset");
    rst = 1'b0;
    repeat (7) @(negedge clk);
    req(7'h41, 5'd0);
    idle_wait();
    req(7'h10, 5'd1);
    idle_wait();

    // back-to-back: request held high
    for (int k = 0; k < 150; k++) begin
      dbgreq = 1'b1;
      dbgsel = 7'($urandom);
      dbglen = 5'($urandom_range(0, 3));
      @(negedge clk);
    end
    dbgreq = 1'b0;
    idle_wait();

    // random mix
    for (int k = 0; k < 400; k++) begin
      dbgreq = ($urandom_range(0, 3) == 0);
      dbgsel = 7'($urandom);
      dbglen = 5'($urandom_range(0, 5));
      @(negedge clk);
    end
    dbgreq = 1'b0;
    idle_wait();

    check("queue_words_left", 32'(wq.size()), 32'd0);
    check("queue_dataen_left", 32'(aq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
